pjon_addressing_unit: RTL and testbench
=======================================

Name: pjon_addressing_unit

Overview:
PJON layer-3 addressing stage between the host-side wrapper and the PJDL link-layer block. The send path buffers AXI-Stream beats from the wrapper in a small FIFO and passes them unchanged to PJDL. The receive path filters frames from PJDL by receiver ID, the first byte of a frame. Matching, broadcast or ACK bytes are forwarded to the wrapper; all other frames are drained and discarded.

Parameters:
BufferSize, 1, send-path FIFO depth in beats; minimum 1.
axis_req_t, type, AXI-Stream request struct: tvalid plus t.{data[7:0], strb, keep, last, id, dest, user[1:0]}.
axis_rsp_t, type, AXI-Stream response struct: tready.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
axis_read_req_i  in  axis_req_t  send stream from wrapper.
axis_read_rsp_o  out  axis_rsp_t  ready to wrapper.
axis_read_req_o  out  axis_req_t  send stream to PJDL.
axis_read_rsp_i  in  axis_rsp_t  ready from PJDL.
axis_write_req_i  in  axis_req_t  received stream from PJDL.
axis_write_rsp_o  out  axis_rsp_t  ready to PJDL.
axis_write_req_o  out  axis_req_t  filtered stream to wrapper.
axis_write_rsp_i  in  axis_rsp_t  ready from wrapper.
start_ack_receiving_i  in  1  pulse from PJDL: the next received frame is an ACK, so skip the address check.
pjon_device_id_i  in  8  own PJON device ID.
router_mode_i  in  1  1 = accept every frame regardless of ID.

Behaviour:
- Reset: FIFO empty; axis_read_req_o.tvalid=0; axis_read_rsp_o.tready=1; RX state IDLE; ack_pending=0; axis_write_req_o.tvalid=0.
- Send FIFO: write on axis_read_req_i.tvalid && tready. tready = !full.
- Send FIFO: output is registered, so the first beat appears one cycle after it is written. axis_read_req_o.tvalid = !empty. Pop on tvalid && axis_read_rsp_i.tready.
- Send FIFO: simultaneous push and pop when full is allowed only via the pop freeing space; tready stays !full (no fall-through).
- Send path carries all fields unmodified, including user codes: 00 data byte, 10 ACK request (data = timeout repetitions, last=1), 01 ACK response (data = ACK value, last=1).
- Receive path is combinational, with no added latency; payload fields (data, last, user, strb, keep) pass through unchanged.
- RX FSM states:
  - IDLE, waiting for the first beat of a frame.
  - FWD, forwarding the rest of the frame.
  - DROP, discarding the rest of the frame.
- IDLE first-beat accept condition: ack_eff || router_mode_i || data==pjon_device_id_i || data==8'h00 (broadcast), where ack_eff = ack_pending || start_ack_receiving_i.
- IDLE when accepted: axis_write_req_o.tvalid = in.tvalid; axis_write_rsp_o.tready = axis_write_rsp_i.tready.
- IDLE when rejected: output tvalid=0; axis_write_rsp_o.tready=1.
- On first-beat handshake: if last=1, stay IDLE; else go to FWD when accepted or DROP when rejected.
- ack_pending clears on the first-beat handshake.
- FWD: pass-through handshake. Return to IDLE on the handshake of a beat with last=1.
- DROP: output tvalid=0, tready=1. Return to IDLE on the handshake of a last=1 beat.
- start_ack_receiving_i sets ack_pending. A pulse coinciding with an IDLE first beat applies to that beat. A pulse arriving in FWD/DROP applies to the next frame.
- Send and receive paths are independent and may be active in the same cycle.
- Reset mid-frame aborts immediately to the reset state; partially buffered send data is lost.

Test Plan:
- Send: push 01,02,03,F0(last) then 05,06,07,F0(last) with PJDL ready → identical sequence and last flags on axis_read_req_o. With PJDL tready held 0 and BufferSize=1 → wrapper tready drops after one beat; no beat lost or duplicated.
- ACK request: push data 09, user 10, last 1 → appears on axis_read_req_o with data 09, user 10, last 1. ACK response: push 05, user 01 → forwarded unchanged.
- Address match: router_mode=0, ID=01; frame 01,00,06,54,41,5A(last) → all six beats forwarded in order, last only on 5A.
- Filtering: router_mode=0, ID=01; frame 02,02,03,04(last) → nothing on axis_write_req_o; PJDL tready stays 1 throughout. A following broadcast frame 00,… is forwarded.
- Router mode: router_mode=1, same 02,… frame → forwarded intact.
- ACK: router_mode=0; pulse start_ack_receiving_i, then single beat 01 (last=1) → forwarded. Repeat with beat 06 → also forwarded. A later non-matching frame is dropped, confirming ack_pending cleared.

Source files
------------

// File: rtl/pjon_addressing_unit.sv
// PJON layer-3 addressing stage: buffered send path towards PJDL and a
// receiver-ID filter on the receive path towards the host wrapper.
package pjon_axis_pkg;
  typedef struct packed {
    logic [7:0] data;
    logic       strb;
    logic       keep;
    logic       last;
    logic [3:0] id;
    logic [3:0] dest;
    logic [1:0] user;
  } axis_t_chan_t;

  typedef struct packed {
    logic         tvalid;
    axis_t_chan_t t;
  } axis_req_t;

  typedef struct packed {
    logic tready;
  } axis_rsp_t;
endpackage

module pjon_addressing_unit #(
  parameter int unsigned BufferSize = 32'd1,
  parameter type axis_req_t = pjon_axis_pkg::axis_req_t,
  parameter type axis_rsp_t = pjon_axis_pkg::axis_rsp_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  axis_req_t  axis_read_req_i,
  output axis_rsp_t  axis_read_rsp_o,
  output axis_req_t  axis_read_req_o,
  input  axis_rsp_t  axis_read_rsp_i,
  input  axis_req_t  axis_write_req_i,
  output axis_rsp_t  axis_write_rsp_o,
  output axis_req_t  axis_write_req_o,
  input  axis_rsp_t  axis_write_rsp_i,
  input  logic       start_ack_receiving_i,
  input  logic [7:0] pjon_device_id_i,
  input  logic       router_mode_i
);

  localparam int unsigned Depth = (BufferSize < 32'd1) ? 32'd1 : BufferSize;
  localparam int unsigned PtrW  = (Depth > 32'd1) ? $clog2(Depth) : 32'd1;
  localparam int unsigned CntW  = $clog2(Depth + 32'd1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 32'd1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_FWD  = 2'd1,
    RX_DROP = 2'd2
  } rx_state_e;

  axis_req_t       mem_r [Depth];
  logic [PtrW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CntW-1:0] count_r;
  logic            full_s, empty_s, push_s, pop_s;

  rx_state_e state_r, state_s;
  logic      ack_pending_r, ack_pending_s;
  logic      accept_s, rx_valid_s, rx_ready_s, first_hs_s;

  // Send FIFO flags and handshakes; no fall-through, so a full FIFO refuses even while popping
  always_comb begin
    full_s  = (count_r == DepthCnt);
    empty_s = (count_r == {CntW{1'b0}});
    push_s  = axis_read_req_i.tvalid && !full_s;
    pop_s   = !empty_s && axis_read_rsp_i.tready;
    axis_read_rsp_o        = '0;
    axis_read_rsp_o.tready = !full_s;
    axis_read_req_o        = mem_r[rd_ptr_r];
    axis_read_req_o.tvalid = !empty_s;
  end

  // Send FIFO storage; contents are don't-care while empty
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= axis_read_req_i;
    end
  end

  // Send FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      count_r  <= {CntW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= (wr_ptr_r == LastPtr) ? {PtrW{1'b0}} : wr_ptr_r + PtrW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LastPtr) ? {PtrW{1'b0}} : rd_ptr_r + PtrW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Receive filter: decide on the first beat, then forward or drain the rest of the frame
  always_comb begin
    state_s    = state_r;
    rx_valid_s = 1'b0;
    rx_ready_s = 1'b1;
    first_hs_s = 1'b0;
    accept_s   = ack_pending_r || start_ack_receiving_i || router_mode_i ||
                 (axis_write_req_i.t.data == pjon_device_id_i) ||
                 (axis_write_req_i.t.data == 8'h00);
    case (state_r)
      RX_IDLE: begin
        if (accept_s) begin
          rx_valid_s = axis_write_req_i.tvalid;
          rx_ready_s = axis_write_rsp_i.tready;
        end else begin
          rx_valid_s = 1'b0;
          rx_ready_s = 1'b1;
        end
        if (axis_write_req_i.tvalid && rx_ready_s) begin
          first_hs_s = 1'b1;
          if (axis_write_req_i.t.last) begin
            state_s = RX_IDLE;
          end else if (accept_s) begin
            state_s = RX_FWD;
          end else begin
            state_s = RX_DROP;
          end
        end else begin
          state_s = state_r;
        end
      end
      RX_FWD: begin
        rx_valid_s = axis_write_req_i.tvalid;
        rx_ready_s = axis_write_rsp_i.tready;
        if (axis_write_req_i.tvalid && axis_write_rsp_i.tready && axis_write_req_i.t.last) begin
          state_s = RX_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      RX_DROP: begin
        if (axis_write_req_i.tvalid && axis_write_req_i.t.last) begin
          state_s = RX_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = RX_IDLE;
      end
    endcase

    // A pulse landing on the first-beat handshake is consumed by that beat
    if (first_hs_s) begin
      ack_pending_s = 1'b0;
    end else if (start_ack_receiving_i) begin
      ack_pending_s = 1'b1;
    end else begin
      ack_pending_s = ack_pending_r;
    end

    axis_write_req_o         = axis_write_req_i;
    axis_write_req_o.tvalid  = rx_valid_s;
    axis_write_rsp_o         = '0;
    axis_write_rsp_o.tready  = rx_ready_s;
  end

  // Receive FSM state and pending-ACK flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= RX_IDLE;
      ack_pending_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      ack_pending_r <= ack_pending_s;
    end
  end

endmodule

// File: tb/tb_pjon_addressing_unit.sv
// Self-checking bench for pjon_addressing_unit: randomized send and receive
// traffic checked against a frame-level reference model.
module tb_pjon_addressing_unit;
  import pjon_axis_pkg::*;

  localparam int BUF = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axis_req_t  rd_req_in, rd_req_out, wr_req_in, wr_req_out;
  axis_rsp_t  rd_rsp_out, rd_rsp_in, wr_rsp_out, wr_rsp_in;
  logic       start_ack;
  logic [7:0] dev_id;
  logic       router;

  int n_assert = 0;
  int n_fail   = 0;
  bit mdl_ack_pending = 1'b0;

  pjon_addressing_unit #(.BufferSize(BUF)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .axis_read_req_i       (rd_req_in),
    .axis_read_rsp_o       (rd_rsp_out),
    .axis_read_req_o       (rd_req_out),
    .axis_read_rsp_i       (rd_rsp_in),
    .axis_write_req_i      (wr_req_in),
    .axis_write_rsp_o      (wr_rsp_out),
    .axis_write_req_o      (wr_req_out),
    .axis_write_rsp_i      (wr_rsp_in),
    .start_ack_receiving_i (start_ack),
    .pjon_device_id_i      (dev_id),
    .router_mode_i         (router)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic axis_t_chan_t mk(input logic [7:0] d, input logic l, input logic [1:0] u);
    axis_t_chan_t b;
    b.data = d;  b.last = l;  b.user = u;
    b.strb = 1'($urandom);  b.keep = 1'($urandom);
    b.id   = 4'($urandom);  b.dest = 4'($urandom);
    return b;
  endfunction

  // Send path: model is a bounded queue of beats held by the FIFO
  task automatic run_send(input axis_t_chan_t src[$], input int ready_pct, input int max_cycles);
    axis_t_chan_t exp_q[$];
    int idx = 0, got = 0, cyc = 0;
    bit push, pop;
    while (got < src.size() && cyc < max_cycles) begin
      rd_req_in.tvalid = (idx < src.size()) && ($urandom_range(99) < 80);
      if (idx < src.size()) rd_req_in.t = src[idx];
      rd_rsp_in.tready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      chk("send_tready", rd_rsp_out.tready, exp_q.size() < BUF);
      chk("send_tvalid", rd_req_out.tvalid, exp_q.size() > 0);
      if (exp_q.size() > 0) chk("send_beat", rd_req_out.t, exp_q[0]);
      push = rd_req_in.tvalid && (exp_q.size() < BUF);
      pop  = (exp_q.size() > 0) && rd_rsp_in.tready;
      if (pop) begin void'(exp_q.pop_front()); got++; end
      if (push) begin exp_q.push_back(src[idx]); idx++; end
      @(posedge clk); #1;
      cyc++;
    end
    chk("send_done", got, src.size());
    rd_req_in.tvalid = 1'b0;
    rd_rsp_in.tready = 1'b1;
  endtask

  // Receive path: whole frame is forwarded or dropped, decided from the first byte
  task automatic run_rx(input logic [7:0] bytes[$], input int pulse_at, input int max_cycles);
    int n = bytes.size();
    int idx = 0, cyc = 0;
    bit fwd, hs, pulsed = 1'b0;
    axis_t_chan_t cur;
    fwd = mdl_ack_pending || (pulse_at == 0) || router ||
          (bytes[0] == dev_id) || (bytes[0] == 8'h00);
    cur = mk(bytes[0], n == 1, 2'($urandom));
    while (idx < n && cyc < max_cycles) begin
      wr_req_in.t      = cur;
      wr_req_in.tvalid = ($urandom_range(99) < 75);
      wr_rsp_in.tready = ($urandom_range(99) < 70);
      start_ack        = (idx == pulse_at) && !pulsed;
      if (start_ack) pulsed = 1'b1;
      @(negedge clk);
      if (fwd) begin
        chk("rx_fwd_tvalid", wr_req_out.tvalid, wr_req_in.tvalid);
        chk("rx_fwd_tready", wr_rsp_out.tready, wr_rsp_in.tready);
        if (wr_req_in.tvalid) begin
          chk("rx_data", wr_req_out.t.data, cur.data);
          chk("rx_last", wr_req_out.t.last, cur.last);
          chk("rx_user", wr_req_out.t.user, cur.user);
          chk("rx_strb_keep", {wr_req_out.t.strb, wr_req_out.t.keep}, {cur.strb, cur.keep});
        end
        hs = wr_req_in.tvalid && wr_rsp_in.tready;
      end else begin
        chk("rx_drop_tvalid", wr_req_out.tvalid, 1'b0);
        chk("rx_drop_tready", wr_rsp_out.tready, 1'b1);
        hs = wr_req_in.tvalid;
      end
      @(posedge clk); #1;
      start_ack = 1'b0;
      cyc++;
      if (hs) begin
        idx++;
        if (idx < n) cur = mk(bytes[idx], idx == n - 1, 2'($urandom));
      end
    end
    chk("rx_done", idx, n);
    wr_req_in.tvalid = 1'b0;
    mdl_ack_pending  = (pulse_at > 0);
  endtask

  task automatic pulse_ack();
    start_ack = 1'b1;
    @(posedge clk); #1;
    start_ack = 1'b0;
    mdl_ack_pending = 1'b1;
  endtask

  initial begin
    axis_t_chan_t src[$];
    axis_t_chan_t b0, b1;
    logic [7:0] fr[$];
    rst_n = 1'b0;
    rd_req_in = '0; wr_req_in = '0;
    rd_rsp_in.tready = 1'b1; wr_rsp_in.tready = 1'b1;
    start_ack = 1'b0; dev_id = 8'h01; router = 1'b0;
    @(negedge clk);
    chk("reset_rd_tvalid", rd_req_out.tvalid, 1'b0);
    chk("reset_rd_tready", rd_rsp_out.tready, 1'b1);
    chk("reset_wr_tvalid", wr_req_out.tvalid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Send frames plus ACK request/response codes
    src = {mk(8'h01,0,2'b00), mk(8'h02,0,2'b00), mk(8'h03,0,2'b00), mk(8'hF0,1,2'b00),
           mk(8'h05,0,2'b00), mk(8'h06,0,2'b00), mk(8'h07,0,2'b00), mk(8'hF0,1,2'b00),
           mk(8'h09,1,2'b10), mk(8'h05,1,2'b01)};
    run_send(src, 100, 200);
    run_send(src, 50, 400);

    // PJDL stalled: one beat fills the FIFO, nothing lost or duplicated
    b0 = mk(8'h11,0,2'b00); b1 = mk(8'h22,1,2'b00);
    rd_rsp_in.tready = 1'b0; rd_req_in.t = b0; rd_req_in.tvalid = 1'b1;
    @(negedge clk); chk("stall_tready0", rd_rsp_out.tready, 1'b1);
    @(posedge clk); #1; rd_req_in.t = b1;
    @(negedge clk);
    chk("stall_tready1", rd_rsp_out.tready, 1'b0);
    chk("stall_beat0", rd_req_out.t, b0);
    @(posedge clk); #1; rd_rsp_in.tready = 1'b1;
    @(negedge clk);
    chk("stall_full_pop_tready", rd_rsp_out.tready, 1'b0);
    chk("stall_beat0_again", rd_req_out.t, b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_empty_tvalid", rd_req_out.tvalid, 1'b0);
    chk("stall_empty_tready", rd_rsp_out.tready, 1'b1);
    @(posedge clk); #1; rd_req_in.tvalid = 1'b0;
    @(negedge clk); chk("stall_beat1", rd_req_out.t, b1);
    @(posedge clk); #1;

    // Receive directed frames
    fr = {8'h01,8'h00,8'h06,8'h54,8'h41,8'h5A}; run_rx(fr, -1, 200);
    fr = {8'h02,8'h02,8'h03,8'h04};             run_rx(fr, -1, 200);
    fr = {8'h00,8'h11,8'h22};                   run_rx(fr, -1, 200);
    router = 1'b1;
    fr = {8'h02,8'h02,8'h03,8'h04};             run_rx(fr, -1, 200);
    router = 1'b0;
    pulse_ack(); fr = {8'h01};                  run_rx(fr, -1, 200);
    pulse_ack(); fr = {8'h06};                  run_rx(fr, -1, 200);
    fr = {8'h07,8'h08};                         run_rx(fr, -1, 200);
    fr = {8'h06};                               run_rx(fr, 0, 200);
    fr = {8'h03,8'h04,8'h05};                   run_rx(fr, 1, 200);
    fr = {8'h09,8'h0B};                         run_rx(fr, -1, 200);
    fr = {8'h0A};                               run_rx(fr, -1, 200);

    // Reset in mid-frame while a send beat is buffered
    wr_rsp_in.tready = 1'b1; wr_req_in.t = mk(8'h02,0,2'b00); wr_req_in.tvalid = 1'b1;
    @(posedge clk); #1;
    wr_req_in.tvalid = 1'b0;
    rd_rsp_in.tready = 1'b0; rd_req_in.t = mk(8'hAA,0,2'b00); rd_req_in.tvalid = 1'b1;
    @(posedge clk); #1;
    rd_req_in.tvalid = 1'b0;
    @(negedge clk); chk("prereset_rd_tvalid", rd_req_out.tvalid, 1'b1);
    rst_n = 1'b0; #1;
    chk("midreset_rd_tvalid", rd_req_out.tvalid, 1'b0);
    chk("midreset_rd_tready", rd_rsp_out.tready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1; rd_rsp_in.tready = 1'b1; mdl_ack_pending = 1'b0;
    fr = {8'h01,8'h33};                         run_rx(fr, -1, 200);

    // Randomized receive frames
    for (int f = 0; f < 25; f++) begin
      int len = $urandom_range(1, 5);
      int sel = $urandom_range(3);
      int p;
      fr = {};
      for (int k = 0; k < len; k++) fr.push_back(8'($urandom));
      if (sel == 0) fr[0] = dev_id;
      else if (sel == 1) fr[0] = 8'h00;
      router = ($urandom_range(3) == 0);
      p = $urandom_range(4) == 0 ? int'($urandom_range(len - 1)) : -1;
      run_rx(fr, p, 300);
    end
    router = 1'b0;

    // Randomized send traffic
    src = {};
    for (int k = 0; k < 20; k++) src.push_back(mk(8'($urandom), 1'($urandom), 2'($urandom)));
    run_send(src, 60, 600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
